// File: rtl/stage_ctrl_if.sv
// Pipeline control bundle between the hazard/stall controller and the
// five-stage datapath registers.
interface stage_ctrl_if;
   // hazard and memory-ready conditions
   logic i_stall;
   logic d_stall;
   logic load_use;
   logic div_start;
   logic except_m;
   // per-stage register controls
   logic en_f, en_d, en_e, en_m, en_w;
   logic clr_d, clr_e, clr_m, clr_w;
   // redirect and divider status
   logic exc_redirect;
   logic div_busy;
   logic div_done;
   logic div_cancel;

   // datapath side: reports conditions, obeys controls
   modport master (
      output i_stall, d_stall, load_use, div_start, except_m,
      input  en_f, en_d, en_e, en_m, en_w,
      input  clr_d, clr_e, clr_m, clr_w,
      input  exc_redirect, div_busy, div_done, div_cancel
   );

   // controller side
   modport slave (
      input  i_stall, d_stall, load_use, div_start, except_m,
      output en_f, en_d, en_e, en_m, en_w,
      output clr_d, clr_e, clr_m, clr_w,
      output exc_redirect, div_busy, div_done, div_cancel
   );
endinterface

// File: rtl/stage_ctrl.sv
// Pipeline stall/flush controller: resolves exception flush, memory stall,
// multi-cycle divide hold and load-use bubbles into per-stage enables/clears.
module stage_ctrl #(
   parameter int DIV_CYCLES = 32
) (
   input logic         clk,
   input logic         rst,
   stage_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN,
      DIV,
      FLUSH_PEND
   } state_e;

   localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

   state_e     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic       mstall;

   assign mstall = bus.i_stall | bus.d_stall;

   // state and divide counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next-state and stage controls, priority: exception, mem stall, divide, load-use
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      bus.en_f         = 1'b0;
      bus.en_d         = 1'b0;
      bus.en_e         = 1'b0;
      bus.en_m         = 1'b0;
      bus.en_w         = 1'b0;
      bus.clr_d        = 1'b0;
      bus.clr_e        = 1'b0;
      bus.clr_m        = 1'b0;
      bus.clr_w        = 1'b0;
      bus.exc_redirect = 1'b0;
      bus.div_busy     = 1'b0;
      bus.div_done     = 1'b0;
      bus.div_cancel   = 1'b0;

      if (rst) begin
         state_d = RUN;
         cnt_d   = '0;
      end else if ((bus.except_m || state_q == FLUSH_PEND) && !mstall) begin
         // flush: a pending flush completes even if except_m has dropped
         bus.en_f         = 1'b1;
         bus.en_d         = 1'b1;
         bus.en_e         = 1'b1;
         bus.en_m         = 1'b1;
         bus.en_w         = 1'b1;
         bus.clr_d        = 1'b1;
         bus.clr_e        = 1'b1;
         bus.clr_m        = 1'b1;
         bus.exc_redirect = 1'b1;
         bus.div_cancel   = (state_q == DIV) && bus.except_m;
         state_d          = RUN;
      end else if (bus.except_m && state_q != FLUSH_PEND) begin
         // exception blocked by memory stall: freeze and remember the flush
         bus.div_cancel = (state_q == DIV);
         state_d        = FLUSH_PEND;
      end else if (state_q == FLUSH_PEND || mstall) begin
         bus.div_busy = (state_q == DIV);
      end else if (state_q == DIV) begin
         bus.en_m     = 1'b1;
         bus.en_w     = 1'b1;
         bus.clr_m    = 1'b1;
         bus.div_busy = 1'b1;
         if (cnt_q == '0) begin
            bus.div_done = 1'b1;
            bus.en_e     = 1'b1;
            state_d      = RUN;
         end else begin
            cnt_d = cnt_q - 6'd1;
         end
      end else if (bus.div_start) begin
         bus.en_m  = 1'b1;
         bus.en_w  = 1'b1;
         bus.clr_m = 1'b1;
         state_d   = DIV;
         cnt_d     = DIV_LOAD;
      end else if (bus.load_use) begin
         bus.en_e  = 1'b1;
         bus.en_m  = 1'b1;
         bus.en_w  = 1'b1;
         bus.clr_e = 1'b1;
      end else begin
         bus.en_f = 1'b1;
         bus.en_d = 1'b1;
         bus.en_e = 1'b1;
         bus.en_m = 1'b1;
         bus.en_w = 1'b1;
      end
   end

endmodule

// File: doc/stage_ctrl.md
STAGE_CTRL -- requirements
Module: stage_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 32, legal 2..63: cycles a divide holds stages F/D/E.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_stall  in  1  instruction SRAM not ready this cycle.
REQ-005 d_stall  in  1  data SRAM not ready this cycle.
REQ-006 load_use  in  1  D-stage operand depends on a load in E.
REQ-007 div_start  in  1  divide instruction in E requests start.
REQ-008 except_m  in  1  exception or eret committed in M.
REQ-009 en_f, en_d, en_e, en_m, en_w  out  1 each  enable for each stage's pipeline register.
REQ-010 clr_d, clr_e, clr_m, clr_w  out  1 each  synchronous clear (bubble) for each stage's register.
REQ-011 exc_redirect  out  1  one-cycle pulse: fetch loads the exception/eret target PC.
REQ-012 div_busy  out  1  high while divide is in progress.
REQ-013 div_done  out  1  one-cycle pulse on the final divide cycle.
REQ-014 div_cancel  out  1  one-cycle pulse when an in-flight divide is aborted.

Function
REQ-015 FSM states RUN, DIV, FLUSH_PEND; 6-bit down-counter cnt.
REQ-016 Outputs are combinational from state, cnt and inputs.
REQ-017 Define mstall = i_stall | d_stall.
REQ-018 Priority, highest first: exception, memory stall, divide, load-use.
REQ-019 Base case, RUN with no condition active: all en_* = 1, all clr_* = 0, all pulses 0.
REQ-020 Flush cycle, any state with except_m=1 and mstall=0:
- all en_* = 1; clr_d = clr_e = clr_m = 1; clr_w = 0; exc_redirect = 1.
- next state RUN.
REQ-021 Deferred exception, RUN or DIV with except_m=1 and mstall=1:
- all en_* = 0, no clears.
- next state FLUSH_PEND.
REQ-022 FLUSH_PEND:
- all en_* = 0 while mstall=1.
- first cycle with mstall=0: perform the flush cycle of REQ-020 regardless of except_m; next state RUN.
REQ-023 Memory stall, RUN with mstall=1 and no exception: all en_* = 0, no clears, state held.
REQ-024 Divide start, RUN with div_start=1, mstall=0, except_m=0:
- next state DIV; cnt <= DIV_CYCLES-1.
- this cycle en_f = en_d = en_e = 0; en_m = 1; clr_m = 1; en_w = 1.
REQ-025 DIV, no exception and mstall=0:
- en_f = en_d = en_e = 0; en_m = en_w = 1; clr_m = 1; div_busy = 1; cnt decrements.
REQ-026 DIV with mstall=1 and no exception: all en_* = 0; cnt holds; div_busy = 1.
REQ-027 Divide completion, DIV with cnt=0 and mstall=0:
- div_done = 1; en_e = 1, so the E register captures the divider result.
- next state RUN.
REQ-028 Divide abort, DIV with except_m=1:
- div_cancel = 1 in that cycle; divide abandoned.
- flush follows per REQ-020 or REQ-021.
REQ-029 Load-use, RUN with load_use=1, no higher-priority condition:
- en_f = en_d = 0; en_e = 1; clr_e = 1; en_m = en_w = 1.
- one bubble per asserted cycle.
REQ-030 div_start is ignored outside RUN; load_use is ignored in DIV and FLUSH_PEND.
REQ-031 Exactly one of {flush, stall, divide-hold, load-use, base} applies per cycle; a register never sees en=0 together with clr=1.

Reset
REQ-032 While rst=1: next state RUN, cnt <= 0.
REQ-033 While rst=1: all en_* = 0, all clr_* = 0, all pulses and div_busy = 0.
REQ-034 rst overrides every state, including mid-divide and FLUSH_PEND; no pending flush survives reset.
REQ-035 First cycle after rst deasserts follows REQ-019 to REQ-029 from RUN.

Verification
REQ-036 Idle after reset, all inputs 0 -> en_f..en_w = 1, clr_* = 0 every cycle.
REQ-037 load_use=1 for 1 cycle -> that cycle en_f = en_d = 0, clr_e = 1; next cycle base.
REQ-038 DIV_CYCLES=4, div_start pulse at cycle T:
- div_busy high cycles T+1..T+4; div_done at T+4; base at T+5.
- d_stall=1 at T+2 for 2 cycles shifts div_done to T+6.
REQ-039 except_m=1 with d_stall=1 for 3 cycles:
- all en_* = 0 for those 3 cycles.
- 4th cycle: clr_d = clr_e = clr_m = 1, exc_redirect = 1.
REQ-040 except_m=1 at DIV cycle 2 with mstall=0 -> same cycle div_cancel = 1, flush cycle, exc_redirect = 1; next cycle RUN base.
REQ-041 rst=1 asserted mid-DIV and inside FLUSH_PEND:
- outputs 0 per REQ-033.
- after release: RUN, no div_done, no exc_redirect.
